// File: rtl/oled_spi_stream.sv
// SPI byte streamer for the OLED path: a small byte FIFO feeding a CS/SCLK/SDIN/DC serializer.
// Optional build macro OLED_SPI_CS_PER_BYTE_EN: release CS (HOLD -> GAP -> IDLE) after every byte.
module oled_spi_stream #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              IN_VALID,
    output logic                              IN_READY,
    input  logic [7:0]                        IN_DATA,
    input  logic                              IN_DC,
    output logic                              BUSY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_LEVEL,
    output logic                              CS,
    output logic                              SCLK,
    output logic                              SDIN,
    output logic                              DC
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    // FIFO storage: {dc, data} per entry
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, empty, push, pop;
    logic [8:0]       head;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             high_q, high_d;
    logic [7:0]       byte_q, byte_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             sdin_q, sdin_d;
    logic             dc_q, dc_d;

    assign full     = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign IN_READY = !RST && !full;
    assign push     = IN_VALID && IN_READY;
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {IN_DC, IN_DATA};
        end
    end

    // A same-cycle push and pop leave the level unchanged; readiness never looks at pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        high_d  = high_q;
        byte_d  = byte_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        sdin_d  = sdin_q;
        dc_d    = dc_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    byte_d  = head[7:0];
                    dc_d    = head[8];
                    sdin_d  = head[7];
                    cs_d    = 1'b0;
                    sclk_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    high_d  = 1'b0;
                    sclk_d  = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!high_q) begin
                        high_d = 1'b1;
                        sclk_d = 1'b1;
                    end else if (bit_q != 3'd0) begin
                        // next bit is presented at the falling edge
                        bit_d  = bit_q - 3'd1;
                        sdin_d = byte_q[bit_q - 3'd1];
                        high_d = 1'b0;
                        sclk_d = 1'b0;
                    end else begin
`ifdef OLED_SPI_CS_PER_BYTE_EN
                        state_d = S_HOLD;
`else
                        if (!empty) begin
                            pop    = 1'b1;
                            byte_d = head[7:0];
                            dc_d   = head[8];
                            sdin_d = head[7];
                            bit_d  = 3'd7;
                            high_d = 1'b0;
                            sclk_d = 1'b0;
                        end else begin
                            state_d = S_HOLD;
                        end
`endif
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd7;
            high_q   <= 1'b0;
            byte_q   <= '0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b1;
            sdin_q   <= 1'b0;
            dc_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            high_q   <= high_d;
            byte_q   <= byte_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            sdin_q   <= sdin_d;
            dc_q     <= dc_d;
        end
    end

    assign BUSY       = (state_q != S_IDLE) || !empty;
    assign FIFO_LEVEL = level_q;
    assign CS         = cs_q;
    assign SCLK       = sclk_q;
    assign SDIN       = sdin_q;
    assign DC         = dc_q;

endmodule

// File: tb/tb_oled_spi_stream.sv
// Scoreboard bench for oled_spi_stream: stimulus queues expected bytes and CS windows, an SPI monitor decodes and compares.
module tb_oled_spi_stream;

    localparam int D     = 2;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] IN_DATA = 8'h00;
    logic       IN_DC = 1'b0;
    logic       BUSY;
    logic [2:0] FIFO_LEVEL;
    logic       CS, SCLK, SDIN, DC;

    oled_spi_stream #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .CS_GAP(GAP)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_DATA(IN_DATA), .IN_DC(IN_DC), .BUSY(BUSY), .FIFO_LEVEL(FIFO_LEVEL),
        .CS(CS), .SCLK(SCLK), .SDIN(SDIN), .DC(DC)
    );

    always #5 CLK = ~CLK;

    int         n_vec = 0;
    int         n_miss = 0;
    logic [8:0] exp_q[$];
    int         win_q[$];

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // SPI monitor
    bit         mon_en = 1'b0;
    bit         in_win = 1'b0;
    bit         seen_rise = 1'b0;
    int         cyc = 0;
    int         win_len = 0;
    int         gap_len = 0;
    int         last_gap = 0;
    int         bit_cnt = 0;
    int         bytes_in_win = 0;
    int         last_start = 0;
    logic [7:0] sh = 8'h00;
    logic       prev_sclk = 1'b1;
    logic [8:0] e;

    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            in_win    = 1'b0;
            seen_rise = 1'b0;
            bit_cnt   = 0;
            prev_sclk = 1'b1;
        end else if (mon_en) begin
            if (CS == 1'b0) begin
                if (!in_win) begin
                    if (seen_rise) begin
                        check("cs_gap_min", int'(gap_len >= GAP + 1), 1);
                        last_gap = gap_len;
                    end
                    in_win = 1'b1;
                    win_len = 0;
                    bytes_in_win = 0;
                    bit_cnt = 0;
                end
                win_len++;
                if (prev_sclk == 1'b1 && SCLK == 1'b0 && exp_q.size() > 0)
                    check("dc_at_fall", int'(DC), int'(exp_q[0][8]));
                if (prev_sclk == 1'b0 && SCLK == 1'b1) begin
                    if (bit_cnt == 0) begin
                        if (bytes_in_win > 0) check("byte_spacing", cyc - last_start, 16 * D);
                        last_start = cyc;
                    end
                    sh = {sh[6:0], SDIN};
                    bit_cnt++;
                    if (bit_cnt == 8) begin
                        bit_cnt = 0;
                        bytes_in_win++;
                        $display("rx byte 0x%02h dc=%0b at cycle %0d", sh, DC, cyc);
                        if (exp_q.size() == 0) begin
                            check("unexpected_byte", int'({DC, sh}), -1);
                        end else begin
                            e = exp_q.pop_front();
                            check("byte", int'({DC, sh}), int'(e));
                        end
                    end
                end
            end else if (in_win) begin
                in_win = 1'b0;
                seen_rise = 1'b1;
                gap_len = 1;
                if (win_q.size() == 0) check("unexpected_window", win_len, -1);
                else check("cs_low_len", win_len, win_q.pop_front());
            end else begin
                gap_len++;
            end
            prev_sclk = SCLK;
        end
    end

    task automatic push(input logic [7:0] d, input logic dc, input bit expect_it);
        int t = 0;
        IN_DATA = d;
        IN_DC = dc;
        IN_VALID = 1'b1;
        @(negedge CLK);
        while (!IN_READY && t < 200) begin
            @(negedge CLK);
            t++;
        end
        check("push_accept", int'(IN_READY), 1);
        if (IN_READY && expect_it) exp_q.push_back({dc, d});
        $display("push 0x%02h dc=%0b", d, dc);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic expect_windows(input int n);
`ifdef OLED_SPI_CS_PER_BYTE_EN
        for (int i = 0; i < n; i++) win_q.push_back(18 * D);
`else
        win_q.push_back((2 + 16 * n) * D);
`endif
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge CLK);
        while ((BUSY || exp_q.size() > 0 || CS != 1'b1) && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        check(name, int'(t < 3000), 1);
        repeat (5) @(negedge CLK);
        check({name, "_busy"}, int'(BUSY), 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int lows;
        logic [7:0] vals [6];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        vals[3] = 8'h44; vals[4] = 8'h55; vals[5] = 8'h66;

        // reset values
        @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", int'(IN_READY), 0);
        check("rst_cs", int'(CS), 1);
        check("rst_sclk", int'(SCLK), 1);
        check("rst_sdin", int'(SDIN), 0);
        check("rst_dc", int'(DC), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_level", int'(FIFO_LEVEL), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);
        check("ready_after_rst", int'(IN_READY), 1);
        @(posedge CLK);
        #1;

        // single byte
        expect_windows(1);
        push(8'hA5, 1'b0, 1'b1);
        wait_idle("single_idle");

        // streaming
        expect_windows(3);
        push(8'hAF, 1'b0, 1'b1);
        push(8'h3C, 1'b1, 1'b1);
        push(8'hFF, 1'b1, 1'b1);
        wait_idle("stream_idle");

        // full FIFO while a transfer runs
        expect_windows(5);
        push(8'h5A, 1'b1, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        check("full_level_start", int'(FIFO_LEVEL), 0);
        for (int i = 0; i < 6; i++) begin
            IN_VALID = 1'b1;
            IN_DATA = vals[i];
            IN_DC = i[0];
            @(negedge CLK);
            check("full_ready", int'(IN_READY), (i < 4) ? 1 : 0);
            if (i < 4) exp_q.push_back({i[0], vals[i]});
            $display("offer 0x%02h dc=%0b", vals[i], i[0]);
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("full_level", int'(FIFO_LEVEL), 4);
        check("full_ready_low", int'(IN_READY), 0);
        wait_idle("full_idle");

        // reset mid-transfer
        push(8'h81, 1'b0, 1'b0);
        push(8'h11, 1'b1, 1'b0);
        push(8'h22, 1'b1, 1'b0);
        t = 0;
        @(negedge CLK);
        while ((bit_cnt != 4 || SCLK != 1'b0) && t < 500) begin
            @(negedge CLK);
            t++;
        end
        check("reach_bit3", int'(t < 500), 1);
        check("mid_level", int'(FIFO_LEVEL), 2);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_ready", int'(IN_READY), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("mid_cs", int'(CS), 1);
        check("mid_sclk", int'(SCLK), 1);
        check("mid_level0", int'(FIFO_LEVEL), 0);
        check("mid_busy", int'(BUSY), 0);
        lows = 0;
        repeat (60) begin
            @(negedge CLK);
            if (CS == 1'b0) lows++;
        end
        check("mid_quiet", lows, 0);
        @(posedge CLK);
        #1;

        // two bytes: one window by default, two windows with per-byte CS
        expect_windows(2);
        push(8'h00, 1'b0, 1'b1);
        push(8'h10, 1'b0, 1'b1);
        wait_idle("pair_idle");
`ifdef OLED_SPI_CS_PER_BYTE_EN
        check("pair_gap", last_gap, GAP + 1);
`endif

        check("exp_drained", exp_q.size(), 0);
        check("win_drained", win_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
